div_unit: RTL and testbench

Iterative RISC-V M-extension divider covering DIV, DIVU, REM and REMU, the counterpart to the combinational multiplier in the execute stage. It uses a radix-2 restoring algorithm on operand magnitudes, then applies sign correction. RISC-V divide-by-zero and signed-overflow results are returned on a one-cycle fast path. A start/busy/done handshake lets the control unit stall the pipeline while a division is in flight.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/div_unit_if.sv | 24 ++
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 130 +++++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and state type for the M-extension multiply/divide units.
package muldiv_pkg;

    // funct3 codes; MDFunc[2]=1 selects the divider
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the control unit and the divider.
// Handshake: start is sampled only when busy=0; done is a one-cycle pulse
// with DivOut valid in that cycle; busy stays high while a division is running.
interface div_unit_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] A;
    logic [DWIDTH-1:0] B;
    logic [2:0]        MDFunc;
    logic              start;
    logic [DWIDTH-1:0] DivOut;
    logic              busy;
    logic              done;

    modport master (
        output A, B, MDFunc, start,
        input  DivOut, busy, done
    );

    modport slave (
        input  A, B, MDFunc, start,
        output DivOut, busy, done
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left, then
// subtract the divisor when it fits and record a quotient 1.
module div_step #(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH:0]   rem,
    input  logic [DWIDTH-1:0] quo,
    input  logic [DWIDTH-1:0] divisor,
    output logic [DWIDTH:0]   rem_next,
    output logic [DWIDTH-1:0] quo_next
);
    logic [DWIDTH+1:0] shifted;
    logic [DWIDTH+1:0] wide_div;

    always_comb begin
        shifted  = {rem, quo[DWIDTH-1]};
        wide_div = {2'b00, divisor};
        if (shifted >= wide_div) begin
            rem_next = (DWIDTH+1)'(shifted - wide_div);
            quo_next = {quo[DWIDTH-2:0], 1'b1};
        end else begin
            rem_next = (DWIDTH+1)'(shifted);
            quo_next = {quo[DWIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: restoring division on magnitudes,
// sign fix-up afterwards, and a single-cycle path for x/0 and overflow.
module div_unit
    import muldiv_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus,
    output div_state_t dbg_state
);
    localparam int                CW        = $clog2(DWIDTH) + 1;
    localparam logic [CW-1:0]     LAST_ITER = CW'(DWIDTH - 1);
    localparam logic [DWIDTH-1:0] MOST_NEG  = {1'b1, {(DWIDTH-1){1'b0}}};

    div_state_t        state, state_next;
    logic [CW-1:0]     cnt;
    logic [DWIDTH:0]   rem, rem_step;
    logic [DWIDTH-1:0] quo, quo_step, divisor, dout, res_mag;
    logic              is_rem, neg_res, done_r;

    logic              op_signed, a_neg, b_neg, div_zero, overflow;
    logic [DWIDTH-1:0] a_mag, b_mag, fast_res;
    logic              accept, fast_done, step_en, finish;

    // Operand decode from the live inputs; only consumed on the accept edge.
    always_comb begin
        op_signed = ~bus.MDFunc[0];
        a_neg     = op_signed & bus.A[DWIDTH-1];
        b_neg     = op_signed & bus.B[DWIDTH-1];
        a_mag     = a_neg ? -bus.A : bus.A;
        b_mag     = b_neg ? -bus.B : bus.B;
        div_zero  = (bus.B == '0);
        overflow  = op_signed && (bus.A == MOST_NEG) && (bus.B == '1);
        if (div_zero) begin
            fast_res = bus.MDFunc[1] ? bus.A : '1;
        end else begin
            fast_res = bus.MDFunc[1] ? '0 : bus.A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fast_done  = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && bus.MDFunc[2]) begin
                    accept = 1'b1;
                    if (div_zero || overflow) begin
                        fast_done = 1'b1;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                step_en = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_next = SIGN;
                end
            end
            SIGN: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    div_step #(.DWIDTH(DWIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // quo starts as the dividend magnitude and shifts into the quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            is_rem  <= 1'b0;
            neg_res <= 1'b0;
            dout    <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= fast_done | finish;
            if (accept) begin
                cnt     <= '0;
                rem     <= '0;
                quo     <= a_mag;
                divisor <= b_mag;
                is_rem  <= bus.MDFunc[1];
                neg_res <= bus.MDFunc[1] ? a_neg : (a_neg ^ b_neg);
            end
            if (step_en) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt + CW'(1);
            end
            if (fast_done) begin
                dout <= fast_res;
            end
            if (finish) begin
                dout <= neg_res ? -res_mag : res_mag;
            end
        end
    end

    assign res_mag    = is_rem ? rem[DWIDTH-1:0] : quo;
    assign bus.DivOut = dout;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_r;
    assign dbg_state  = state;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: driver pushes expected results and done cycles
// into queues, a negedge monitor pops and compares on every done pulse.
module tb_div_unit;
    import muldiv_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    div_state_t dbg_state;

    div_unit_if #(.DWIDTH(32)) bus ();

    div_unit #(.DWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          cyc      = 0;
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    int          d0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];
    string       tag_q[$];
    logic [31:0] mon_exp;
    int          mon_cyc;
    string       mon_tag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = cyc_q.pop_front();
                mon_tag = tag_q.pop_front();
                chk({mon_tag, " result"}, bus.DivOut, mon_exp);
                chk({mon_tag, " latency_cycle"}, 32'(cyc), 32'(mon_cyc));
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 of the done cycle.
    task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input int lat,
                         input int poke);
        int waited;
        bus.MDFunc = f;
        bus.A      = a;
        bus.B      = b;
        bus.start  = 1'b1;
        exp_q.push_back(expv);
        cyc_q.push_back(cyc + lat);
        tag_q.push_back(tag);
        @(negedge clk); #1;
        bus.start  = 1'b0;
        bus.A      = $urandom;
        bus.B      = $urandom;
        bus.MDFunc = 3'($urandom_range(0, 7));
        chk({tag, " busy_after_accept"}, 32'(bus.busy), (lat > 1) ? 32'd1 : 32'd0);
        if (poke > 0) begin
            repeat (poke - 1) @(negedge clk);
            #1;
            bus.MDFunc = MD_DIV;
            bus.A      = 32'd5;
            bus.B      = 32'd1;
            bus.start  = 1'b1;
            @(negedge clk); #1;
            bus.start  = 1'b0;
        end
        waited = 0;
        while (exp_q.size() != 0 && waited < 80) begin
            @(negedge clk); #1;
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done in %0d cycles, expected one done", tag, waited);
            exp_q.delete();
            cyc_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.MDFunc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset DivOut", bus.DivOut, 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        issue("div_20_m3",   MD_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, 0);
        issue("rem_20_m3",   MD_REM,  32'd20,        32'hFFFF_FFFD, 32'd2,         34, 0);
        issue("divu_max_2",  MD_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 34, 0);
        issue("remu_max_2",  MD_REMU, 32'hFFFF_FFFF, 32'd2,         32'd1,         34, 0);
        issue("rem_m7_2",    MD_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
        issue("div_m100_7",  MD_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 34, 0);
        issue("rem_m100_7",  MD_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 34, 0);
        issue("div_100_m7",  MD_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);
        issue("rem_100_m7",  MD_REM,  32'd100,       32'hFFFF_FFF9, 32'd2,         34, 0);
        issue("divu_100_7",  MD_DIVU, 32'd100,       32'd7,         32'd14,        34, 0);

        issue("div_7_0",     MD_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 1, 0);
        issue("divu_7_0",    MD_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, 1, 0);
        issue("rem_7_0",     MD_REM,  32'd7,         32'd0,         32'd7,         1, 0);
        issue("rem_m7_0",    MD_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1, 0);
        issue("remu_min_0",  MD_REMU, 32'h8000_0000, 32'd0,         32'h8000_0000, 1, 0);

        issue("div_ovf",     MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        issue("rem_ovf",     MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);
        issue("divu_ovfops", MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, 0);
        issue("remu_ovfops", MD_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);

        // Multiplier code in IDLE must be ignored entirely.
        d0         = done_cnt;
        bus.MDFunc = MD_MUL;
        bus.A      = 32'd9;
        bus.B      = 32'd3;
        bus.start  = 1'b1;
        @(negedge clk); #1;
        bus.start  = 1'b0;
        chk("mul_code busy", 32'(bus.busy), 32'd0);
        chk("mul_code state", 32'(dbg_state), 32'(IDLE));
        repeat (3) @(negedge clk);
        #1;
        chk("mul_code done_count", 32'(done_cnt - d0), 32'd0);

        // start while busy must not be queued or disturb the running op.
        d0 = done_cnt;
        issue("div_poke", MD_DIV, 32'd1000, 32'd10, 32'd100, 34, 10);
        repeat (5) @(negedge clk);
        #1;
        chk("div_poke done_count", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of a division.
        bus.MDFunc = MD_DIV;
        bus.A      = 32'd1000;
        bus.B      = 32'd3;
        bus.start  = 1'b1;
        @(negedge clk); #1;
        bus.start  = 1'b0;
        repeat (14) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst DivOut", bus.DivOut, 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        chk("midrst state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        d0  = done_cnt;
        repeat (40) @(negedge clk);
        #1;
        chk("midrst done_count", 32'(done_cnt - d0), 32'd0);
        issue("div_after_rst", MD_DIV, 32'd100, 32'd7, 32'd14, 34, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
